// File: rtl/mips_fetch_decode_unit_if.sv
// rtl/mips_fetch_decode_unit_if.sv - loader, stall and fetch/decode bus of the MIPS front end
// master drives loader writes and stall; slave is the fetch/decode unit.
interface mips_fetch_decode_unit_if;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        stall_in;
   logic [31:0] pc_out;
   logic [31:0] pc_decode_out;
   logic [31:0] insn_out;
   logic        insn_valid;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic [31:0] jtarget;
   logic        is_r;
   logic        is_i;
   logic        is_j;
   logic        is_nop;
   logic        illegal;

   modport master (
      output load_en, load_addr, load_data, stall_in,
      input  pc_out, pc_decode_out, insn_out, insn_valid, opcode, rs, rt, rd, shamt,
             funct, imm_sext, imm_zext, jtarget, is_r, is_i, is_j, is_nop, illegal
   );

   modport slave (
      input  load_en, load_addr, load_data, stall_in,
      output pc_out, pc_decode_out, insn_out, insn_valid, opcode, rs, rt, rd, shamt,
             funct, imm_sext, imm_zext, jtarget, is_r, is_i, is_j, is_nop, illegal
   );
endinterface

// File: rtl/mips_fetch_decode_unit.sv
// rtl/mips_fetch_decode_unit.sv - instruction memory, fetch PC and MIPS-I decoder
// Loader writes words while load_en is high; otherwise fetch streams sequential words into decode.
module mips_fetch_decode_unit #(
   parameter logic [31:0] MEM_BASE  = 32'h8002_0000,
   parameter int          MEM_BYTES = 1048576
) (
   input logic                     clock,
   input logic                     reset,
   mips_fetch_decode_unit_if.slave bus
);

   localparam int          WORDS     = MEM_BYTES / 4;
   localparam int          IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   logic [31:0] mem [WORDS];

   logic [31:0] wr_off;
   logic [31:0] rd_off;
   logic        wr_hit;
   logic        rd_hit;
   logic        fetch;

   logic [31:0] pc_q;
   logic [31:0] pc_dec_q;
   logic [31:0] insn_q;
   logic        valid_q;

   // Offsets wrap below MEM_BASE, so a single unsigned compare covers both range ends.
   assign wr_off = bus.load_addr - MEM_BASE;
   assign rd_off = pc_q - MEM_BASE;
   assign wr_hit = wr_off < MEM_LIMIT;
   assign rd_hit = rd_off < MEM_LIMIT;
   assign fetch  = !bus.load_en && !bus.stall_in;

   always_ff @(posedge clock) begin
      if (bus.load_en && wr_hit) begin
         mem[wr_off[IDX_W+1:2]] <= bus.load_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q     <= MEM_BASE;
         pc_dec_q <= MEM_BASE;
         insn_q   <= '0;
         valid_q  <= 1'b0;
      end else if (fetch) begin
         pc_dec_q <= pc_q;
         insn_q   <= rd_hit ? mem[rd_off[IDX_W+1:2]] : '0;
         valid_q  <= 1'b1;
         pc_q     <= pc_q + 32'd4;
      end else begin
         valid_q  <= 1'b0;
      end
   end

   assign bus.pc_out        = pc_q;
   assign bus.pc_decode_out = pc_dec_q;
   assign bus.insn_out      = insn_q;
   assign bus.insn_valid    = valid_q;

   assign bus.opcode   = insn_q[31:26];
   assign bus.rs       = insn_q[25:21];
   assign bus.rt       = insn_q[20:16];
   assign bus.rd       = insn_q[15:11];
   assign bus.shamt    = insn_q[10:6];
   assign bus.funct    = insn_q[5:0];
   assign bus.imm_sext = {{16{insn_q[15]}}, insn_q[15:0]};
   assign bus.imm_zext = {16'h0000, insn_q[15:0]};

   logic [3:0] jt_region;
   logic       supported;

   // Region of pc_decode_out+4: the upper nibble only bumps when bits [27:2] are all ones.
   assign jt_region   = pc_dec_q[31:28] + {3'b000, &pc_dec_q[27:2]};
   assign bus.jtarget = {jt_region, insn_q[25:0], 2'b00};

   always_comb begin
      supported = 1'b0;
      case (insn_q[31:26])
         6'h00: begin
            case (insn_q[5:0])
               6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h10, 6'h12,
               6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22,
               6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: supported = 1'b1;
               default: supported = 1'b0;
            endcase
         end
         6'h01: supported = (insn_q[20:16] == 5'd0) || (insn_q[20:16] == 5'd1);
         6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
         6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
         6'h20, 6'h23, 6'h24, 6'h28, 6'h2B: supported = 1'b1;
         default: supported = 1'b0;
      endcase
   end

   assign bus.is_r    = insn_q[31:26] == 6'h00;
   assign bus.is_j    = (insn_q[31:26] == 6'h02) || (insn_q[31:26] == 6'h03);
   assign bus.is_i    = !bus.is_r && !bus.is_j;
   assign bus.is_nop  = insn_q == 32'h0000_0000;
   assign bus.illegal = valid_q && !supported;

endmodule

// File: tb/tb_mips_fetch_decode_unit.sv
// tb/tb_mips_fetch_decode_unit.sv - scoreboard bench for mips_fetch_decode_unit
// Stimulus queues hand-computed decode results; a negedge monitor pops one per valid word.
module tb_mips_fetch_decode_unit;

   localparam logic [31:0] BASE  = 32'h8002_0000;
   localparam int          BYTES = 64;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  flags;   // {is_r, is_i, is_j, is_nop, illegal}
      logic [1:0]  chk;     // [0] fields/immediates, [1] jtarget
      logic [31:0] imm_s;
      logic [31:0] imm_z;
      logic [31:0] jt;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_err    = 0;
   exp_t sb[$];
   exp_t vec[19];

   mips_fetch_decode_unit_if bus ();

   mips_fetch_decode_unit #(.MEM_BASE(BASE), .MEM_BYTES(BYTES)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] flags,
                               input logic [1:0] chk, input logic [31:0] imm_s, input logic [31:0] imm_z,
                               input logic [31:0] jt);
      exp_t e;
      e.pc = pc; e.insn = insn; e.flags = flags; e.chk = chk;
      e.imm_s = imm_s; e.imm_z = imm_z; e.jt = jt;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      bus.load_en   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      @(posedge clock);
      #1;
   endtask

   task automatic run(input int n);
      bus.stall_in = 1'b0;
      repeat (n) @(posedge clock);
      #1;
      bus.stall_in = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      @(negedge clock);
      forever begin
         if (bus.insn_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid_pc", bus.pc_decode_out, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("pc_decode_out", bus.pc_decode_out, e.pc);
               check("insn_out", bus.insn_out, e.insn);
               check("flags_r_i_j_nop_illegal",
                     {27'd0, bus.is_r, bus.is_i, bus.is_j, bus.is_nop, bus.illegal}, {27'd0, e.flags});
               if (e.chk[0]) begin
                  check("fields", {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}, e.insn);
                  check("imm_sext", bus.imm_sext, e.imm_s);
                  check("imm_zext", bus.imm_zext, e.imm_z);
               end
               if (e.chk[1]) check("jtarget", bus.jtarget, e.jt);
            end
         end
         @(negedge clock);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0]  = mk(BASE + 32'h00, 32'h27BD_FFE8, 5'b01000, 2'b01, 32'hFFFF_FFE8, 32'h0000_FFE8, 32'h0);
      vec[1]  = mk(BASE + 32'h04, 32'h0085_1021, 5'b10000, 2'b01, 32'h0000_1021, 32'h0000_1021, 32'h0);
      vec[2]  = mk(BASE + 32'h08, 32'h0C00_8010, 5'b00100, 2'b10, 32'h0, 32'h0, 32'h8002_0040);
      vec[3]  = mk(BASE + 32'h0C, 32'hFC00_0000, 5'b01001, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[4]  = mk(BASE + 32'h10, 32'h0000_0000, 5'b10010, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[5]  = mk(BASE + 32'h14, 32'h3C01_1234, 5'b01000, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[6]  = mk(BASE + 32'h18, 32'h0000_000D, 5'b10001, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[7]  = mk(BASE + 32'h1C, 32'h0411_0005, 5'b01001, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[8]  = mk(BASE + 32'h20, 32'h0401_0003, 5'b01000, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[9]  = mk(BASE + 32'h24, 32'h8C82_0004, 5'b01000, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[10] = mk(BASE + 32'h28, 32'h0800_0000, 5'b00100, 2'b10, 32'h0, 32'h0, 32'h8000_0000);
      vec[11] = mk(BASE + 32'h2C, 32'hAC82_0008, 5'b01000, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[12] = mk(BASE + 32'h30, 32'h00A6_3025, 5'b10000, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[13] = mk(BASE + 32'h34, 32'h7C00_0000, 5'b01001, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[14] = mk(BASE + 32'h38, 32'h8C82_0000, 5'b01000, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[15] = mk(BASE + 32'h3C, 32'h0000_0000, 5'b10010, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[16] = mk(BASE + 32'h40, 32'h0000_0000, 5'b10010, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[17] = mk(BASE + 32'h44, 32'h0000_0000, 5'b10010, 2'b00, 32'h0, 32'h0, 32'h0);
      vec[18] = mk(BASE + 32'h48, 32'h0000_0000, 5'b10010, 2'b00, 32'h0, 32'h0, 32'h0);

      reset         = 1'b1;
      bus.load_en   = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      bus.stall_in  = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_pc_out", bus.pc_out, BASE);
      check("reset_pc_decode_out", bus.pc_decode_out, BASE);
      check("reset_insn_out", bus.insn_out, 32'h0);
      check("reset_insn_valid", {31'd0, bus.insn_valid}, 32'd0);
      check("reset_illegal", {31'd0, bus.illegal}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) load_word(vec[i].pc, vec[i].insn);
      load_word(BASE + 32'h40, 32'hDEAD_BEEF);
      load_word(BASE - 32'h4, 32'hCAFE_F00D);
      bus.load_en = 1'b0;
      @(negedge clock);
      check("pc_out_after_load", bus.pc_out, BASE);
      check("valid_after_load", {31'd0, bus.insn_valid}, 32'd0);
      @(posedge clock);
      #1;

      for (int i = 0; i < 17; i++) sb.push_back(vec[i]);
      run(4);
      for (int c = 0; c < 3; c++) begin
         @(posedge clock);
         @(negedge clock);
         check("stall_pc_out", bus.pc_out, BASE + 32'h10);
         check("stall_insn_out", bus.insn_out, 32'hFC00_0000);
         check("stall_insn_valid", {31'd0, bus.insn_valid}, 32'd0);
         check("stall_illegal", {31'd0, bus.illegal}, 32'd0);
      end
      @(posedge clock);
      #1;
      run(13);
      drain();
      check("pc_out_after_stream", bus.pc_out, BASE + 32'h44);

      sb.push_back(vec[17]);
      sb.push_back(vec[18]);
      bus.stall_in = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset        = 1'b0;
      bus.stall_in = 1'b1;
      check("midreset_pc_out", bus.pc_out, BASE);
      check("midreset_pc_decode_out", bus.pc_decode_out, BASE);
      check("midreset_insn_valid", {31'd0, bus.insn_valid}, 32'd0);
      drain();

      sb.push_back(vec[0]);
      sb.push_back(vec[1]);
      run(2);
      drain();
      check("pc_out_after_restart", bus.pc_out, BASE + 32'h08);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
